// File: rtl/iter_divider.sv
// Iterative restoring radix-2 divider for DIV/DIVU/REM/REMU and their *W forms.
// Computes one quotient bit per cycle on magnitudes; signs are fixed up on the final step.
module iter_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        div_ready,
  input  logic        div_cancel,
  input  logic        div_signed,
  input  logic        div_word,
  input  logic        div_rem_sel,
  input  logic [63:0] dividend,
  input  logic [63:0] divisor,
  output logic [63:0] div_rem_data,
  output logic        div_finish,
  output logic        div_busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      r_state;
  logic [6:0]  r_cnt;
  logic [63:0] r_rem;
  logic [63:0] r_quo;
  logic [63:0] r_dvs;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_word;
  logic        r_rem_sel;
  logic        r_special;
  logic [63:0] r_spec_res;
  logic [63:0] r_data;
  logic        r_finish;
  logic        r_busy;

  // Operands at the operating width, sign- or zero-extended to 64 bits
  logic [63:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_dvd_sx;
  logic        w_a_neg, w_b_neg, w_dz, w_ovf;
  logic [63:0] w_spec_res;

  assign w_a_ext  = div_word ? {{32{div_signed & dividend[31]}}, dividend[31:0]} : dividend;
  assign w_b_ext  = div_word ? {{32{div_signed & divisor[31]}},  divisor[31:0]}  : divisor;
  assign w_a_neg  = div_signed & w_a_ext[63];
  assign w_b_neg  = div_signed & w_b_ext[63];
  assign w_a_mag  = w_a_neg ? (~w_a_ext + 64'd1) : w_a_ext;
  assign w_b_mag  = w_b_neg ? (~w_b_ext + 64'd1) : w_b_ext;
  assign w_dvd_sx = div_word ? {{32{dividend[31]}}, dividend[31:0]} : dividend;

  assign w_dz  = div_word ? (divisor[31:0] == 32'd0) : (divisor == 64'd0);
  assign w_ovf = div_signed & (div_word
               ? (dividend[31:0] == 32'h8000_0000 && divisor[31:0] == 32'hFFFF_FFFF)
               : (dividend == 64'h8000_0000_0000_0000 && divisor == 64'hFFFF_FFFF_FFFF_FFFF));

  always_comb begin
    w_spec_res = 64'd0;
    if (w_dz)       w_spec_res = div_rem_sel ? w_dvd_sx : 64'hFFFF_FFFF_FFFF_FFFF;
    else if (w_ovf) w_spec_res = div_rem_sel ? 64'd0 : w_dvd_sx;
  end

  // One restoring step: shift in next dividend bit, subtract if it fits
  logic [64:0] w_sh, w_diff;
  logic        w_ge;
  logic [63:0] w_rem_nx, w_quo_nx, w_mag, w_res, w_final;
  logic        w_neg;

  assign w_sh     = {r_rem, r_quo[63]};
  assign w_diff   = w_sh - {1'b0, r_dvs};
  assign w_ge     = ~w_diff[64];
  assign w_rem_nx = w_ge ? w_diff[63:0] : w_sh[63:0];
  assign w_quo_nx = {r_quo[62:0], w_ge};
  assign w_mag    = r_rem_sel ? w_rem_nx : w_quo_nx;
  assign w_neg    = r_rem_sel ? r_neg_r : r_neg_q;
  assign w_res    = w_neg ? (~w_mag + 64'd1) : w_mag;
  assign w_final  = r_word ? {{32{w_res[31]}}, w_res[31:0]} : w_res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 7'd0;
      r_rem      <= 64'd0;
      r_quo      <= 64'd0;
      r_dvs      <= 64'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_word     <= 1'b0;
      r_rem_sel  <= 1'b0;
      r_special  <= 1'b0;
      r_spec_res <= 64'd0;
      r_data     <= 64'd0;
      r_finish   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      if (div_cancel) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_cnt   <= 7'd0;
      end else begin
        case (r_state)
          IDLE: if (div_ready) begin
            r_state    <= BUSY;
            r_busy     <= 1'b1;
            r_cnt      <= div_word ? 7'd32 : 7'd64;
            r_rem      <= 64'd0;
            // Word magnitudes are left-aligned so the MSB is consumed first
            r_quo      <= div_word ? {w_a_mag[31:0], 32'd0} : w_a_mag;
            r_dvs      <= w_b_mag;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_word     <= div_word;
            r_rem_sel  <= div_rem_sel;
            r_special  <= w_dz | w_ovf;
            r_spec_res <= w_spec_res;
          end
          BUSY: begin
            if (r_special) begin
              r_data   <= r_spec_res;
              r_state  <= DONE;
              r_finish <= 1'b1;
            end else begin
              r_rem <= w_rem_nx;
              r_quo <= w_quo_nx;
              r_cnt <= r_cnt - 7'd1;
              if (r_cnt == 7'd1) begin
                r_data   <= w_final;
                r_state  <= DONE;
                r_finish <= 1'b1;
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign div_rem_data = r_data;
  assign div_finish   = r_finish;
  assign div_busy     = r_busy;

endmodule

// File: tb/tb_iter_divider.sv
// Randomized scoreboard bench for iter_divider: driver pushes model results,
// a negedge monitor pops and compares on every finish pulse.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_ready = 1'b0, div_cancel = 1'b0, div_signed = 1'b0, div_word = 1'b0, div_rem_sel = 1'b0;
  logic [63:0] dividend = 64'd0, divisor = 64'd0;
  logic [63:0] div_rem_data;
  logic        div_finish, div_busy;

  iter_divider dut (
    .clk(clk), .rst(rst), .div_ready(div_ready), .div_cancel(div_cancel),
    .div_signed(div_signed), .div_word(div_word), .div_rem_sel(div_rem_sel),
    .dividend(dividend), .divisor(divisor),
    .div_rem_data(div_rem_data), .div_finish(div_finish), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0, n_pass = 0, cyc = 0;
  logic [63:0] last_exp = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, got, want, cyc);
  endtask

  // Reference: plain arithmetic at the operating width
  function automatic logic [63:0] ref_res(input logic [63:0] a, input logic [63:0] b,
                                          input bit s, input bit w, input bit r);
    logic [31:0] a32, b32, q32, m32;
    logic [63:0] q, m;
    a32 = a[31:0];
    b32 = b[31:0];
    if (w) begin
      if (b32 == 32'd0) begin q32 = 32'hFFFF_FFFF; m32 = a32; end
      else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; m32 = 32'd0; end
      else if (s) begin q32 = $signed(a32) / $signed(b32); m32 = $signed(a32) % $signed(b32); end
      else begin q32 = a32 / b32; m32 = a32 % b32; end
      q = {{32{q32[31]}}, q32};
      m = {{32{m32[31]}}, m32};
    end else begin
      if (b == 64'd0) begin q = '1; m = a; end
      else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin q = a; m = 64'd0; end
      else if (s) begin q = $signed(a) / $signed(b); m = $signed(a) % $signed(b); end
      else begin q = a / b; m = a % b; end
    end
    return r ? m : q;
  endfunction

  function automatic int ref_lat(input logic [63:0] a, input logic [63:0] b, input bit s, input bit w);
    if (w) begin
      if (b[31:0] == 32'd0 || (s && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)) return 1;
      return 32;
    end
    if (b == 64'd0 || (s && a == 64'h8000_0000_0000_0000 && b == '1)) return 1;
    return 64;
  endfunction

  // Monitor: every finish pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && div_finish) begin
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL spurious_finish: got finish=1 want no pending op (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", div_rem_data, e.res);
        chk("latency", 64'(cyc - e.acc - 1), 64'(e.lat));
        chk("busy_in_done", {63'd0, div_busy}, 64'd1);
        last_exp = e.res;
      end
    end
  end

  // Issue one request; returns at the negedge after the accepting edge
  task automatic start_op(input logic [63:0] a, input logic [63:0] b,
                          input bit s, input bit w, input bit r, input bit push);
    int t;
    exp_t e;
    @(negedge clk);
    dividend = a; divisor = b; div_signed = s; div_word = w; div_rem_sel = r; div_ready = 1'b1;
    t = 0;
    while (div_busy && t < 200) begin @(negedge clk); t++; end
    if (div_busy) begin
      n_chk++;
      $display("FAIL accept_timeout: got busy=1 want 0");
    end
    if (push) begin
      e.res = ref_res(a, b, s, w, r);
      e.lat = ref_lat(a, b, s, w);
      e.acc = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    // Inputs after acceptance must be ignored
    dividend = {$urandom, $urandom}; divisor = {$urandom, $urandom};
    div_signed = 1'($urandom); div_word = 1'($urandom); div_rem_sel = 1'($urandom);
    div_ready = 1'($urandom);
  endtask

  task automatic wait_finish(input bit hold);
    int t;
    t = 0;
    while (!div_finish && t < 200) begin @(negedge clk); t++; end
    if (!div_finish) begin
      n_chk++;
      $display("FAIL finish_timeout: got finish=0 want 1");
    end
    if (!hold) div_ready = 1'b0;
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                       input bit s, input bit w, input bit r, input bit hold);
    start_op(a, b, s, w, r, 1'b1);
    wait_finish(hold);
  endtask

  initial begin
    logic [63:0] a, b;
    #12;
    chk("reset_data", div_rem_data, 64'd0);
    chk("reset_busy", {63'd0, div_busy}, 64'd0);
    chk("reset_finish", {63'd0, div_finish}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op(64'd100, 64'd7, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    chk("idle_after_done", {63'd0, div_busy}, 64'd0);
    do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 0, 1, 0);
    do_op(64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1, 0, 0, 0);
    do_op(64'h1234, 64'd0, 0, 0, 0, 0);
    do_op(64'h1234, 64'd0, 1, 0, 1, 0);
    do_op(64'h8000_0000_0000_0000, '1, 1, 0, 0, 0);
    do_op(64'h8000_0000_0000_0000, '1, 1, 0, 1, 0);
    do_op(64'hDEAD_BEEF_FFFF_FFF9, 64'd2, 1, 1, 0, 0);
    do_op(64'h0000_0000_8000_0000, 64'd1, 0, 1, 0, 0);
    do_op(64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1, 0);

    // Cancel at E10 of a 64-step op
    start_op(64'd12345, 64'd17, 0, 0, 0, 0);
    repeat (9) @(negedge clk);
    div_cancel = 1'b1; div_ready = 1'b0;
    @(negedge clk);
    div_cancel = 1'b0;
    chk("cancel_busy", {63'd0, div_busy}, 64'd0);
    chk("cancel_finish", {63'd0, div_finish}, 64'd0);
    chk("cancel_data", div_rem_data, last_exp);
    repeat (80) @(negedge clk);

    // Asynchronous reset mid-operation
    start_op(64'd99999, 64'd3, 0, 0, 0, 0);
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_data", div_rem_data, 64'd0);
    chk("rst_busy", {63'd0, div_busy}, 64'd0);
    chk("rst_finish", {63'd0, div_finish}, 64'd0);
    last_exp = 64'd0;
    div_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_op(64'd100, 64'd7, 0, 0, 0, 0);

    // Back-to-back with ready held across DONE
    do_op(64'd1000, 64'd33, 0, 0, 1, 1);
    do_op(64'hFFFF_FFFF_FFFF_FC18, 64'd33, 1, 0, 0, 1);
    do_op(64'd77, 64'd5, 0, 1, 0, 0);

    for (int i = 0; i < 30; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: b = 64'd0;
        1: b = '1;
        2: begin a = 64'h8000_0000_8000_0000; b = '1; end
        3: b = 64'($urandom_range(1, 300));
        4: b = {32'd0, $urandom};
        default: ;
      endcase
      do_op(a, b, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    div_ready = 1'b0;

    repeat (5) @(negedge clk);
    chk("queue_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
